div_unit: RTL

Iterative 32-bit radix-2 divider for the MIPS execute stage. Sits directly upstream of the HI/LO register pair: it accepts DIV/DIVU operands, computes quotient and remainder over multiple cycles, and produces a one-cycle write strobe with remainder on the HI bus and quotient on the LO bus. Pipeline control stalls on `busy` and can annul an in-flight operation on exception flush.

---
 rtl/div_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider feeding the HI/LO register pair
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_qneg;
    logic             r_rneg;

    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_accept;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;

    assign w_a_abs  = (signed_div && a[WIDTH-1]) ? -a : a;
    assign w_b_abs  = (signed_div && b[WIDTH-1]) ? -b : b;
    assign w_accept = start && !annul;

    // r_quo starts as the dividend; its MSB feeds the remainder while quotient bits fill from the LSB
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_div});
    assign w_sub    = w_shift[WIDTH-1:0] - r_div;
    assign w_rem_nx = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

    assign busy    = (r_state == RUN);
    assign hilo_we = (r_state == FINISH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, FINISH: begin
                if (w_accept) begin
                    w_next_state = (w_b_abs == '0) ? FINISH : RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (annul) begin
                    w_next_state = IDLE;
                end else if (r_cnt == LAST) begin
                    w_next_state = FINISH;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            case (r_state)
                IDLE, FINISH: begin
                    if (w_accept) begin
                        r_cnt  <= '0;
                        r_rem  <= '0;
                        r_quo  <= w_a_abs;
                        r_div  <= w_b_abs;
                        r_qneg <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_rneg <= signed_div & a[WIDTH-1];
                        // divide by zero skips RUN, so its result is loaded on the way into FINISH here
                        if (w_b_abs == '0) begin
                            hi_o <= a;
                            lo_o <= '1;
                        end
                    end
                end
                RUN: begin
                    if (!annul) begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            hi_o <= r_rneg ? -w_rem_nx : w_rem_nx;
                            lo_o <= r_qneg ? -w_quo_nx : w_quo_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
